// File: rtl/snake_step_ctrl.sv
// ---------------------------------------------------------------------------
// snake_step_ctrl
//
// Game-step sequencer for the snake board. It counts vertical-sync pulses.
// Every FRAMES_PER_STEP frames it advances the snake head one cell, wrapping
// at the board edges. It then issues two writes to the board memory over a
// req/ack handshake: first the old head cell becomes BODY, then the new head
// cell becomes HEAD. The same memory is read by the VGA controller.
//
// Ports
//   iVGA_CLK      in   1   pixel clock, the only clock
//   iRST_n        in   1   asynchronous active-low reset
//   up/down/left/right
//                 in   1   button levels, active-high, already synchronous
//   iVS_start     in   1   one-cycle pulse at the start of vertical blank
//   iPause        in   1   level; freezes frame counting while high
//   wr_req        out  1   board write request
//   wr_ack        in   1   board write accepted
//   wr_addr       out 32   board cell index = row*BOARD_W + col
//   wr_data       out  2   cell code (1 = HEAD, 2 = BODY)
//   headRow       out 32   current head row
//   headCol       out 32   current head column
//   dir           out  2   committed heading (0 UP, 1 DOWN, 2 LEFT, 3 RIGHT)
//   step_done     out  1   one-cycle pulse when both writes of a step finish
//   overrun       out  1   sticky; set when a step tick arrives while busy
// ---------------------------------------------------------------------------
module snake_step_ctrl #(
    parameter int unsigned BOARD_W         = 32,
    parameter int unsigned BOARD_H         = 24,
    parameter int unsigned FRAMES_PER_STEP = 8
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        iVS_start,
    input  logic        iPause,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic [31:0] wr_addr,
    output logic [1:0]  wr_data,
    output logic [31:0] headRow,
    output logic [31:0] headCol,
    output logic [1:0]  dir,
    output logic        step_done,
    output logic        overrun
);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] CELL_HEAD = 2'd1;
    localparam logic [1:0] CELL_BODY = 2'd2;

    localparam int unsigned CNT_W =
        (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    localparam logic [31:0] ROW_RST = 32'(BOARD_H / 2);
    localparam logic [31:0] COL_RST = 32'(BOARD_W / 2);
    localparam logic [31:0] ROW_MAX = 32'(BOARD_H - 1);
    localparam logic [31:0] COL_MAX = 32'(BOARD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_WR_BODY,
        ST_WR_HEAD
    } state_e;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] wrap_dec(input logic [31:0] v,
                                             input logic [31:0] vmax);
        return (v == 32'd0) ? vmax : v - 32'd1;
    endfunction

    function automatic logic [31:0] wrap_inc(input logic [31:0] v,
                                             input logic [31:0] vmax);
        return (v == vmax) ? 32'd0 : v + 32'd1;
    endfunction

    function automatic logic [31:0] cell_addr(input logic [31:0] r,
                                              input logic [31:0] c);
        return r * 32'(BOARD_W) + c;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [CNT_W-1:0] frame_q,    frame_d;
    logic [1:0]       pend_q,     pend_d;
    logic [1:0]       dir_q,      dir_d;
    logic [31:0]      head_row_q, head_row_d;
    logic [31:0]      head_col_q, head_col_d;
    logic             wr_req_q,   wr_req_d;
    logic [31:0]      wr_addr_q,  wr_addr_d;
    logic [1:0]       wr_data_q,  wr_data_d;
    logic             done_q,     done_d;
    logic             overrun_q,  overrun_d;

    logic             tick;
    logic             btn_vld;
    logic [1:0]       btn_dir;
    logic [31:0]      next_row;
    logic [31:0]      next_col;

    // ------------------------------------------------------------------
    // Frame counter: a tick fires on the sync pulse that wraps the count.
    // ------------------------------------------------------------------
    always_comb begin
        frame_d = frame_q;
        tick    = 1'b0;
        if (iVS_start && !iPause) begin
            if (frame_q == CNT_LAST) begin
                frame_d = '0;
                tick    = 1'b1;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Direction latch. A reverse request is dropped outright rather than
    // falling through to a lower-priority button, so the snake can never
    // fold back onto its own neck. Opposite headings differ only in bit 0.
    // ------------------------------------------------------------------
    always_comb begin
        btn_vld = 1'b1;
        btn_dir = DIR_UP;
        if (up) begin
            btn_dir = DIR_UP;
        end else if (down) begin
            btn_dir = DIR_DOWN;
        end else if (left) begin
            btn_dir = DIR_LEFT;
        end else if (right) begin
            btn_dir = DIR_RIGHT;
        end else begin
            btn_vld = 1'b0;
        end

        pend_d = pend_q;
        if (btn_vld && (btn_dir != (dir_q ^ 2'b01))) begin
            pend_d = btn_dir;
        end
    end

    // Next head position for the heading about to be committed.
    always_comb begin
        next_row = head_row_q;
        next_col = head_col_q;
        case (pend_q)
            DIR_UP:    next_row = wrap_dec(head_row_q, ROW_MAX);
            DIR_DOWN:  next_row = wrap_inc(head_row_q, ROW_MAX);
            DIR_LEFT:  next_col = wrap_dec(head_col_q, COL_MAX);
            default:   next_col = wrap_inc(head_col_q, COL_MAX);
        endcase
    end

    // ------------------------------------------------------------------
    // Step FSM. The old head address is latched straight into wr_addr in
    // MOVE, so no separate copy of the previous position is kept.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        head_row_d = head_row_q;
        head_col_d = head_col_q;
        wr_req_d   = wr_req_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (tick && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                dir_d      = pend_q;
                head_row_d = next_row;
                head_col_d = next_col;
                wr_req_d   = 1'b1;
                wr_addr_d  = cell_addr(head_row_q, head_col_q);
                wr_data_d  = CELL_BODY;
                state_d    = ST_WR_BODY;
            end
            ST_WR_BODY: begin
                if (wr_ack) begin
                    // head_*_q already holds the new head here.
                    wr_addr_d = cell_addr(head_row_q, head_col_q);
                    wr_data_d = CELL_HEAD;
                    state_d   = ST_WR_HEAD;
                end
            end
            ST_WR_HEAD: begin
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            pend_q     <= DIR_RIGHT;
            dir_q      <= DIR_RIGHT;
            head_row_q <= ROW_RST;
            head_col_q <= COL_RST;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 2'd0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            pend_q     <= pend_d;
            dir_q      <= dir_d;
            head_row_q <= head_row_d;
            head_col_q <= head_col_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign wr_req    = wr_req_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign headRow   = head_row_q;
    assign headCol   = head_col_q;
    assign dir       = dir_q;
    assign step_done = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl with default parameters (32x24 board,
// 8 frames per step). Expected values are worked out by hand in the comments.
module tb_snake_step_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        up, down, left, right;
    logic        iVS_start, iPause;
    logic        wr_req, wr_ack;
    logic [31:0] wr_addr;
    logic [1:0]  wr_data;
    logic [31:0] headRow, headCol;
    logic [1:0]  dir;
    logic        step_done, overrun;

    int n_vec = 0;
    int n_err = 0;

    // Accepted-write log and step_done pulse count.
    int wa [0:511];
    int wd [0:511];
    int nwr    = 0;
    int sd_cnt = 0;

    always #5 clk = ~clk;

    snake_step_ctrl dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .iVS_start(iVS_start),
        .iPause   (iPause),
        .wr_req   (wr_req),
        .wr_ack   (wr_ack),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .headRow  (headRow),
        .headCol  (headCol),
        .dir      (dir),
        .step_done(step_done),
        .overrun  (overrun)
    );

    always @(posedge clk) begin
        if (wr_req && wr_ack && nwr < 512) begin
            wa[nwr] <= int'(wr_addr);
            wd[nwr] <= int'(wr_data);
            nwr     <= nwr + 1;
        end
        if (step_done) sd_cnt <= sd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); iVS_start = 1'b1;
            @(negedge clk); iVS_start = 1'b0;
        end
    endtask

    task automatic press(input logic [3:0] b);
        @(negedge clk); {up, down, left, right} = b;
        @(negedge clk);
        @(negedge clk); {up, down, left, right} = 4'b0000;
    endtask

    task automatic wait_done(input int s0);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (sd_cnt != s0) done = 1'b1;
        end
        chk("step_done_seen", 32'(done), 32'd1);
    endtask

    task automatic do_step();
        int s0;
        s0 = sd_cnt;
        pulses(8);
        wait_done(s0);
    endtask

    initial begin
        int  base;
        bit  stable;
        bit  saw_req;

        rst_n = 1'b0;
        {up, down, left, right} = 4'b0000;
        iVS_start = 1'b0;
        iPause    = 1'b0;
        wr_ack    = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_headRow",   headRow,   32'd12);
        chk("rst_headCol",   headCol,   32'd16);
        chk("rst_dir",       dir,       32'd3);
        chk("rst_wr_req",    wr_req,    32'd0);
        chk("rst_wr_addr",   wr_addr,   32'd0);
        chk("rst_wr_data",   wr_data,   32'd0);
        chk("rst_step_done", step_done, 32'd0);
        chk("rst_overrun",   overrun,   32'd0);
        @(negedge clk); rst_n = 1'b1;

        // First step, cycle by cycle. Tick on the 8th pulse (cycle N).
        pulses(7);
        @(negedge clk); iVS_start = 1'b1;
        @(negedge clk); iVS_start = 1'b0;          // N+1: MOVE
        chk("t1_req_move", wr_req, 32'd0);
        chk("t1_col_move", headCol, 32'd16);
        @(negedge clk);                            // N+2: WR_BODY
        chk("t1_req_body",  wr_req,  32'd1);
        chk("t1_addr_body", wr_addr, 32'd400);     // 12*32+16
        chk("t1_data_body", wr_data, 32'd2);
        chk("t1_col_new",   headCol, 32'd17);
        chk("t1_dir",       dir,     32'd3);
        @(negedge clk);                            // N+3: WR_HEAD
        chk("t1_req_head",  wr_req,  32'd1);
        chk("t1_addr_head", wr_addr, 32'd401);     // 12*32+17
        chk("t1_data_head", wr_data, 32'd1);
        chk("t1_sd_low",    step_done, 32'd0);
        @(negedge clk);                            // N+4: IDLE, step_done
        chk("t1_sd_pulse",  step_done, 32'd1);
        chk("t1_req_idle",  wr_req,    32'd0);
        @(negedge clk);
        chk("t1_sd_once",   step_done, 32'd0);
        chk("t1_nwr",       nwr,       32'd2);
        chk("t1_wa0", wa[0], 32'd400);
        chk("t1_wd0", wd[0], 32'd2);
        chk("t1_wa1", wa[1], 32'd401);
        chk("t1_wd1", wd[1], 32'd1);
        chk("t1_sd_cnt", sd_cnt, 32'd1);

        // Column wrap: 14 steps to col 31, then one more to col 0.
        for (int k = 0; k < 14; k++) do_step();
        chk("t2_col31", headCol, 32'd31);
        base = nwr;
        do_step();
        chk("t2_col0",   headCol, 32'd0);
        chk("t2_row",    headRow, 32'd12);
        chk("t2_wa_body", wa[base],   32'd415);    // 12*32+31
        chk("t2_wa_head", wa[base+1], 32'd384);    // 12*32+0
        chk("t2_wd_head", wd[base+1], 32'd1);

        // up+down together: up wins. Head (12,0) -> (11,0).
        press(4'b1100);
        do_step();
        chk("t3_dir_up", dir,     32'd0);
        chk("t3_row11",  headRow, 32'd11);
        for (int k = 0; k < 11; k++) do_step();
        chk("t3_row0", headRow, 32'd0);
        base = nwr;
        do_step();
        chk("t3_row23",    headRow, 32'd23);
        chk("t3_wa_body",  wa[base],   32'd0);
        chk("t3_wa_head",  wa[base+1], 32'd736);   // 23*32+0
        // up+left while UP: still UP, row 22.
        press(4'b1010);
        do_step();
        chk("t3_upleft_dir", dir,     32'd0);
        chk("t3_upleft_row", headRow, 32'd22);
        // down+left while UP: down is the pick and is a reverse, so ignored.
        press(4'b0110);
        do_step();
        chk("t3_rev_dir", dir,     32'd0);
        chk("t3_rev_row", headRow, 32'd21);
        chk("t3_rev_col", headCol, 32'd0);

        // right -> (21,1) RIGHT; left ignored -> (21,2); down -> (22,2).
        press(4'b0001);
        do_step();
        chk("t4_dir_right", dir,     32'd3);
        chk("t4_col1",      headCol, 32'd1);
        press(4'b0010);
        do_step();
        chk("t4_left_ign_dir", dir,     32'd3);
        chk("t4_left_ign_col", headCol, 32'd2);
        press(4'b0100);
        do_step();
        chk("t4_dir_down", dir,     32'd1);
        chk("t4_row22",    headRow, 32'd22);

        // Back-pressure: ack held low, extra tick dropped.
        chk("t5_ovr_pre", overrun, 32'd0);
        wr_ack = 1'b0;
        pulses(8);
        @(negedge clk);                            // WR_BODY
        chk("t5_req",     wr_req,  32'd1);
        chk("t5_addr",    wr_addr, 32'd706);       // 22*32+2
        chk("t5_data",    wr_data, 32'd2);
        chk("t5_row23",   headRow, 32'd23);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            iVS_start = (i < 16) && (i % 2 == 0);
            if (!(wr_req === 1'b1 && wr_addr === 32'd706 && wr_data === 2'd2)) stable = 1'b0;
        end
        @(negedge clk); iVS_start = 1'b0;
        chk("t5_stable",  32'(stable), 32'd1);
        chk("t5_overrun", overrun, 32'd1);
        base = nwr;
        wr_ack = 1'b1;
        wait_done(sd_cnt);
        chk("t5_nwr",     nwr - base,   32'd2);
        chk("t5_wa_body", wa[base],     32'd706);
        chk("t5_wd_body", wd[base],     32'd2);
        chk("t5_wa_head", wa[base+1],   32'd738);  // 23*32+2
        chk("t5_wd_head", wd[base+1],   32'd1);
        chk("t5_ovr_sticky", overrun, 32'd1);

        // Pause: 20 sync pulses, no activity.
        iPause  = 1'b1;
        saw_req = 1'b0;
        base    = nwr;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            iVS_start = (i < 40) && (i % 2 == 0);
            if (wr_req !== 1'b0) saw_req = 1'b1;
        end
        iPause = 1'b0;
        chk("t6_no_req", 32'(saw_req), 32'd0);
        chk("t6_nwr",    nwr - base,   32'd0);
        chk("t6_row",    headRow,      32'd23);

        // Reset in WR_BODY. DOWN from row 23 wraps to row 0.
        wr_ack = 1'b0;
        pulses(8);
        @(negedge clk);
        chk("t7_req",   wr_req,  32'd1);
        chk("t7_addr",  wr_addr, 32'd738);
        chk("t7_row0",  headRow, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_req_async", wr_req,  32'd0);
        chk("t7_row",       headRow, 32'd12);
        chk("t7_col",       headCol, 32'd16);
        chk("t7_dir",       dir,     32'd3);
        chk("t7_overrun",   overrun, 32'd0);
        chk("t7_addr0",     wr_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1; wr_ack = 1'b1;

        // Normal step after reset: same writes as the first step.
        base = nwr;
        do_step();
        chk("t8_wa_body", wa[base],   32'd400);
        chk("t8_wa_head", wa[base+1], 32'd401);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
